keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 29 ++
 rtl/kp_debounce.sv | 70 +++++++
 rtl/keypad_scanner.sv | 114 +++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared matrix geometry, the key-event record and a priority helper
//   used by the keypad scanner and its debounce sub-module.
`timescale 1ns/1ps
package keypad_scanner_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 8;
   localparam int KEY_W    = 5;
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
   localparam int ROW_W    = $clog2(NUM_ROWS);

   // One reported key transition: press = 1 for a press, 0 for a release.
   typedef struct packed {
      logic             press;
      logic [KEY_W-1:0] code;
   } kp_event_t;

   // Index of the lowest set bit; callers only use it when v != 0.
   function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
      logic [KEY_W-1:0] idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = KEY_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/kp_debounce.sv
// kp_debounce
//   Assembles one complete key frame per row scan and accepts it as the
//   debounced matrix once DEBOUNCE_FRAMES consecutive frames agree.
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   tick        : end of the current row period; columns are sampled now
//   row_idx     : row currently driven
//   col_sync    : synchronized active-low column sense
//   debounced   : accepted pressed map, indexed row*8+col
`timescale 1ns/1ps
module kp_debounce
   import keypad_scanner_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [ROW_W-1:0]    row_idx,
   input  logic [NUM_COLS-1:0] col_sync,
   output logic [NUM_KEYS-1:0] debounced
);

   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   logic [NUM_KEYS-1:0] frame_q, frame_d;
   logic [NUM_KEYS-1:0] prev_q, prev_d;
   logic [NUM_KEYS-1:0] deb_q, deb_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                frame_done;

   assign frame_done = tick && (row_idx == ROW_W'(NUM_ROWS - 1));

   always_comb begin
      frame_d = frame_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      if (tick) begin
         frame_d[int'(row_idx) * NUM_COLS +: NUM_COLS] = ~col_sync;
      end
      // frame_d already holds the last row, so compare the finished frame.
      if (frame_done) begin
         if (frame_d == prev_q) begin
            if (cnt_q != CNT_W'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = CNT_W'(1);
         end
         prev_d = frame_d;
         if (cnt_d == CNT_W'(DEBOUNCE_FRAMES)) deb_d = frame_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         deb_q   <= '0;
      end else begin
         frame_q <= frame_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
      end
   end

   assign debounced = deb_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x8 key matrix one row at a time, debounces whole frames and
//   reports each change of the debounced map as a press/release event
//   over a valid/ready handshake, lowest key index first.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   row_n      : active-low row drive (one row low at a time)
//   col_n      : active-low column sense, asynchronous to clk
//   ev_valid   : event presented; ev_ready : consumer accepts it
//   ev_code    : key index row*8+col; ev_press : 1 press, 0 release
//   key_state  : committed pressed map; any_key : OR of key_state
`timescale 1ns/1ps
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                clk,
   input  logic                reset,
   output logic [NUM_ROWS-1:0] row_n,
   input  logic [NUM_COLS-1:0] col_n,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [KEY_W-1:0]    ev_code,
   output logic                ev_press,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                any_key
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [DIV_W-1:0]    div_q, div_d;
   logic                tick;
   logic [ROW_W-1:0]    row_idx_q, row_idx_d;
   logic [NUM_COLS-1:0] col_meta_q, col_sync_q;
   logic [NUM_KEYS-1:0] debounced, diff;
   logic [NUM_KEYS-1:0] key_state_q, key_state_d;
   logic                ev_valid_q, ev_valid_d;
   kp_event_t           ev_q, ev_d;

   assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

   // Row counter wraps 3 -> 0 by its natural 2-bit overflow.
   always_comb begin
      div_d     = tick ? '0 : div_q + 1'b1;
      row_idx_d = tick ? row_idx_q + 1'b1 : row_idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= '0;
         row_idx_q  <= '0;
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         div_q      <= div_d;
         row_idx_q  <= row_idx_d;
         col_meta_q <= col_n;
         col_sync_q <= col_meta_q;
      end
   end

   kp_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .row_idx  (row_idx_q),
      .col_sync (col_sync_q),
      .debounced(debounced)
   );

   assign diff = debounced ^ key_state_q;

   // The event payload is only loaded while idle, so it stays frozen during
   // back-pressure; key_state moves on acceptance, which re-derives diff.
   always_comb begin
      ev_valid_d  = ev_valid_q;
      ev_d        = ev_q;
      key_state_d = key_state_q;
      if (ev_valid_q) begin
         if (ev_ready) begin
            key_state_d[ev_q.code] = ev_q.press;
            ev_valid_d             = 1'b0;
         end
      end else if (diff != '0) begin
         ev_d.code  = lowest_set(diff);
         ev_d.press = debounced[ev_d.code];
         ev_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_valid_q  <= 1'b0;
         ev_q        <= '0;
         key_state_q <= '0;
      end else begin
         ev_valid_q  <= ev_valid_d;
         ev_q        <= ev_d;
         key_state_q <= key_state_d;
      end
   end

   assign row_n     = ~(NUM_ROWS'(1) << row_idx_q);
   assign ev_valid  = ev_valid_q;
   assign ev_code   = ev_q.code;
   assign ev_press  = ev_q.press;
   assign key_state = key_state_q;
   assign any_key   = |key_state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_FRAMES = 2.
//   A behavioural key matrix drives col_n from row_n; expected events are
//   queued when stimulus is applied and a monitor pops them on handshakes.
`timescale 1ns/1ps
module tb_keypad_scanner;

   logic        clk;
   logic        reset;
   logic [3:0]  row_n;
   logic [7:0]  col_n;
   logic        ev_valid;
   logic        ev_ready;
   logic [4:0]  ev_code;
   logic        ev_press;
   logic [31:0] key_state;
   logic        any_key;

   logic [31:0] pressed;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      logic [4:0] code;
      logic       press;
   } exp_t;
   exp_t exp_q[$];

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_FRAMES(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .row_n    (row_n),
      .col_n    (col_n),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_code  (ev_code),
      .ev_press (ev_press),
      .key_state(key_state),
      .any_key  (any_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_n = 8'hFF;
      for (int r = 0; r < 4; r++) begin
         if (row_n[r] == 1'b0) col_n = col_n & ~pressed[r*8 +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_exp(input int code, input logic press);
      exp_t e;
      e.code  = 5'(code);
      e.press = press;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(input string name, input int bound);
      int n;
      n = 0;
      while (n < bound && ev_valid !== 1'b1) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_valid_within_bound"}, 32'(ev_valid), 32'd1);
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while (n < bound && exp_q.size() != 0) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_events_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor: every accepted event must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (!reset && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_event: got code %0d press %0d expected no event",
                        ev_code, ev_press);
            end else begin
               e = exp_q.pop_front();
               check("event_code", 32'(ev_code), 32'(e.code));
               check("event_press", 32'(ev_press), 32'(e.press));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] er;
      reset    = 1'b1;
      ev_ready = 1'b1;
      pressed  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_row_n", 32'(row_n), 32'hE);
      check("reset_ev_valid", 32'(ev_valid), 32'd0);
      check("reset_ev_code", 32'(ev_code), 32'd0);
      check("reset_ev_press", 32'(ev_press), 32'd0);
      check("reset_key_state", key_state, 32'd0);
      check("reset_any_key", 32'(any_key), 32'd0);

      // Row sequence after release, 4 cycles per row
      @(negedge clk) reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         er = ~(4'b0001 << ((k / 4) % 4));
         check("row_sequence", 32'(row_n), 32'(er));
         check("idle_ev_valid", 32'(ev_valid), 32'd0);
      end

      // Key 21 press
      @(negedge clk);
      pressed[21] = 1'b1;
      push_exp(21, 1'b1);
      wait_valid("press21", 48);
      wait_drain("press21", 4);
      @(posedge clk); #1;
      check("press21_key_state", key_state, 32'h0020_0000);
      check("press21_any_key", 32'(any_key), 32'd1);

      // Key 21 contact bouncing every frame: no event expected
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         pressed[21] = ~pressed[21];
         repeat (15) @(negedge clk);
      end
      repeat (48) @(posedge clk);
      #1;
      check("bounce_key_state", key_state, 32'h0020_0000);
      check("bounce_ev_valid", 32'(ev_valid), 32'd0);

      // Keys 3 and 17 together under back-pressure
      @(negedge clk);
      ev_ready    = 1'b0;
      pressed[3]  = 1'b1;
      pressed[17] = 1'b1;
      push_exp(3, 1'b1);
      push_exp(17, 1'b1);
      wait_valid("multi", 64);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("hold_ev_valid", 32'(ev_valid), 32'd1);
         check("hold_ev_code", 32'(ev_code), 32'd3);
         check("hold_ev_press", 32'(ev_press), 32'd1);
      end
      @(negedge clk) ev_ready = 1'b1;
      wait_drain("multi", 40);
      @(posedge clk); #1;
      check("multi_key_state", key_state, 32'h0022_0008);

      // Release everything: ascending order, 21 is a release event
      @(negedge clk);
      push_exp(3, 1'b0);
      push_exp(17, 1'b0);
      push_exp(21, 1'b0);
      pressed = '0;
      wait_drain("release", 80);
      @(posedge clk); #1;
      check("release_key_state", key_state, 32'd0);
      check("release_any_key", 32'(any_key), 32'd0);

      // Reset while an event is pending
      @(negedge clk);
      pressed[1] = 1'b1;
      push_exp(1, 1'b1);
      wait_drain("press1", 80);
      @(negedge clk);
      ev_ready   = 1'b0;
      pressed[2] = 1'b1;
      wait_valid("press2", 64);
      check("press2_ev_code", 32'(ev_code), 32'd2);
      check("press2_key_state", key_state, 32'h0000_0002);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("midreset_ev_valid", 32'(ev_valid), 32'd0);
      check("midreset_key_state", key_state, 32'd0);
      check("midreset_row_n", 32'(row_n), 32'hE);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
